// File: rtl/eth_pkg.sv
// Shared Ethernet/ARP definitions for the RX path and the ARP block.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package eth_pkg;

  localparam int ETH_HDR_BYTES = 14;
  localparam int MAC_W         = 48;
  localparam int IP_W          = 32;
  localparam int ETYPE_W       = 16;
  localparam int HDR_W         = 2 * MAC_W + ETYPE_W;
  localparam int HDR_CNT_W     = 4;

  localparam logic [ETYPE_W-1:0] ETHERTYPE_ARP  = 16'h0806;
  localparam logic [ETYPE_W-1:0] ETHERTYPE_IPV4 = 16'h0800;

  typedef enum logic {
    ST_HDR     = 1'b0,
    ST_PAYLOAD = 1'b1
  } rx_state_e;

  // Wire order of the header: dest first, so shifting bytes in from the
  // bottom leaves dest in the top bits once all 14 bytes have arrived.
  typedef struct packed {
    logic [MAC_W-1:0]   dest_mac;
    logic [MAC_W-1:0]   src_mac;
    logic [ETYPE_W-1:0] eth_type;
  } eth_hdr_t;

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry stream skid buffer carrying data+last+user with registered outputs.
// Latency: 1 cycle input to output; sustains 1 beat/cycle while m_rdy_i is held high.
// Backpressure: s_rdy_o is registered and drops only once the skid entry is occupied.
module axis_skid_buffer #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          s_vld_i,
  output logic          s_rdy_o,
  input  logic [DW-1:0] s_dat_i,
  input  logic          s_last_i,
  input  logic          s_user_i,
  output logic          m_vld_o,
  input  logic          m_rdy_i,
  output logic [DW-1:0] m_dat_o,
  output logic          m_last_o,
  output logic          m_user_o
);

  localparam int BW = DW + 2;

  logic [BW-1:0] out_q, out_d, skid_q, skid_d;
  logic          out_vld_q, out_vld_d, skid_vld_q, skid_vld_d;
  logic          out_pop, in_push;

  assign out_pop = out_vld_q & m_rdy_i;
  assign in_push = s_vld_i & ~skid_vld_q;

  // Fill the output register first; park a beat in the skid entry only when the output is stalled.
  always_comb begin
    out_d      = out_q;
    out_vld_d  = out_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    if (skid_vld_q) begin
      if (out_pop) begin
        out_d      = skid_q;
        skid_vld_d = 1'b0;
      end
    end else if (in_push) begin
      if (!out_vld_q || out_pop) begin
        out_d     = {s_user_i, s_last_i, s_dat_i};
        out_vld_d = 1'b1;
      end else begin
        skid_d     = {s_user_i, s_last_i, s_dat_i};
        skid_vld_d = 1'b1;
      end
    end else if (out_pop) begin
      out_vld_d = 1'b0;
    end
  end

  // Buffer state registers; reset empties both entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q      <= '0;
      out_vld_q  <= 1'b0;
      skid_q     <= '0;
      skid_vld_q <= 1'b0;
    end else begin
      out_q      <= out_d;
      out_vld_q  <= out_vld_d;
      skid_q     <= skid_d;
      skid_vld_q <= skid_vld_d;
    end
  end

  assign s_rdy_o  = ~skid_vld_q;
  assign m_vld_o  = out_vld_q;
  assign m_dat_o  = out_q[DW-1:0];
  assign m_last_o = out_q[DW];
  assign m_user_o = out_q[DW+1];

endmodule

// File: rtl/eth_axis_rx.sv
// Ethernet RX: strips the 14-byte header into parallel fields and forwards the payload stream.
// Latency: header valid 1 cycle after byte 13; payload 1 cycle input to output.
// Backpressure: header bytes stall while a parsed header is unconsumed; payload stalls when the skid buffer is full.
module eth_axis_rx
  import eth_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int HDR_BYTES  = ETH_HDR_BYTES
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tuser,
  output logic                  m_eth_hdr_valid,
  input  logic                  m_eth_hdr_ready,
  output logic [MAC_W-1:0]      m_eth_dest_mac,
  output logic [MAC_W-1:0]      m_eth_src_mac,
  output logic [ETYPE_W-1:0]    m_eth_type,
  output logic [DATA_WIDTH-1:0] m_eth_payload_axis_tdata,
  output logic                  m_eth_payload_axis_tvalid,
  input  logic                  m_eth_payload_axis_tready,
  output logic                  m_eth_payload_axis_tlast,
  output logic                  m_eth_payload_axis_tuser,
  output logic                  busy,
  output logic                  error_header_early_termination
);

  if (DATA_WIDTH != 8) begin : g_bad_width
    $error("eth_axis_rx supports only DATA_WIDTH = 8");
  end
  if (HDR_BYTES != ETH_HDR_BYTES) begin : g_bad_hdr
    $error("eth_axis_rx header length is fixed at 14 bytes");
  end

  rx_state_e            state_q, state_d;
  logic [HDR_CNT_W-1:0] cnt_q, cnt_d;
  eth_hdr_t             hdr_q, hdr_d;
  logic                 hdr_vld_q, hdr_vld_d;
  logic                 busy_q, busy_d;
  logic                 err_q, err_d;
  logic                 live_q;
  logic                 skid_in_vld, skid_in_rdy;
  logic                 in_fire, hdr_fire, hdr_done, pay_last_fire;

  assign in_fire       = s_axis_tvalid & s_axis_tready;
  assign hdr_fire      = in_fire & (state_q == ST_HDR);
  assign hdr_done      = hdr_fire & ~s_axis_tlast & (cnt_q == HDR_CNT_W'(HDR_BYTES - 1));
  assign pay_last_fire = in_fire & (state_q == ST_PAYLOAD) & s_axis_tlast;

  // State register; live_q keeps tready low during reset and for the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_HDR;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      live_q  <= 1'b1;
    end
  end

  // Next state: a complete header enters PAYLOAD, an accepted payload tlast returns to HDR.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_HDR:     if (hdr_done) state_d = ST_PAYLOAD;
      ST_PAYLOAD: if (pay_last_fire) state_d = ST_HDR;
      default:    state_d = ST_HDR;
    endcase
  end

  // Outputs per state: tready and skid-buffer steering depend only on registered state.
  always_comb begin
    s_axis_tready = 1'b0;
    skid_in_vld   = 1'b0;
    case (state_q)
      ST_HDR:     s_axis_tready = live_q & ~hdr_vld_q;
      ST_PAYLOAD: begin
        s_axis_tready = live_q & skid_in_rdy;
        skid_in_vld   = s_axis_tvalid;
      end
      default: ;
    endcase
  end

  // Header capture, byte counting, busy tracking and the early-termination pulse.
  always_comb begin
    cnt_d     = cnt_q;
    hdr_d     = hdr_q;
    hdr_vld_d = hdr_vld_q & ~m_eth_hdr_ready;
    busy_d    = busy_q;
    err_d     = 1'b0;
    if (hdr_fire) begin
      hdr_d  = {hdr_q[HDR_W-DATA_WIDTH-1:0], s_axis_tdata};
      busy_d = 1'b1;
      if (s_axis_tlast) begin
        cnt_d  = '0;
        err_d  = 1'b1;
        busy_d = 1'b0;
      end else if (hdr_done) begin
        cnt_d     = '0;
        hdr_vld_d = 1'b1;
      end else begin
        cnt_d = cnt_q + HDR_CNT_W'(1);
      end
    end
    if (pay_last_fire) busy_d = 1'b0;
  end

  // Header datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      hdr_q     <= '0;
      hdr_vld_q <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      hdr_q     <= hdr_d;
      hdr_vld_q <= hdr_vld_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
    end
  end

  axis_skid_buffer #(.DW(DATA_WIDTH)) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_vld_i  (skid_in_vld),
    .s_rdy_o  (skid_in_rdy),
    .s_dat_i  (s_axis_tdata),
    .s_last_i (s_axis_tlast),
    .s_user_i (s_axis_tuser & s_axis_tlast),
    .m_vld_o  (m_eth_payload_axis_tvalid),
    .m_rdy_i  (m_eth_payload_axis_tready),
    .m_dat_o  (m_eth_payload_axis_tdata),
    .m_last_o (m_eth_payload_axis_tlast),
    .m_user_o (m_eth_payload_axis_tuser)
  );

  assign m_eth_hdr_valid                = hdr_vld_q;
  assign m_eth_dest_mac                 = hdr_q.dest_mac;
  assign m_eth_src_mac                  = hdr_q.src_mac;
  assign m_eth_type                     = hdr_q.eth_type;
  assign busy                           = busy_q;
  assign error_header_early_termination = err_q;

endmodule
